log_divider: RTL and testbench

- Mitchell-approximation signed divider: log domain is subtraction, followed by an antilog step.
- Companion to the team's log multiplier; divides a product-width dividend back down by an operand-width divisor.
- 3-stage pipeline with valid/ready handshake on both sides and full backpressure.
- Sits downstream of the log multiplier in the approximate-arithmetic datapath.

---
 rtl/approx_arith_pkg.sv | 42 ++++
 rtl/lod_log.sv | 32 +++
 rtl/log_divider.sv | 141 ++++++++++++++
 tb/tb_log_divider.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_arith_pkg.sv
// Shared types and widths for the approximate (Mitchell log-domain) arithmetic datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package approx_arith_pkg;

   localparam int DIVIDEND_W_DEF = 16;
   localparam int DIVISOR_W_DEF  = 8;
   localparam int F              = DIVIDEND_W_DEF - 1;        // fraction bits of a log value
   localparam int KW             = $clog2(DIVIDEND_W_DEF);    // width of the integer (MSB index) field
   localparam int DW             = KW + F + 2;                // signed log-difference width

   // Log-domain value: integer part k (MSB index) and F-bit mantissa fraction
   typedef struct packed {
      logic [KW-1:0] k;
      logic [F-1:0]  frac;
   } log_val_t;

   // Payload held in stage 1: signs, zero flags and operand magnitudes
   typedef struct packed {
      logic                      sign;
      logic                      a_neg;
      logic                      za;
      logic                      zb;
      logic [DIVIDEND_W_DEF-1:0] a;
      logic [DIVISOR_W_DEF-1:0]  b;
   } s1_pay_t;

   // Payload held in stage 2: signs, zero flags and the log-domain difference
   typedef struct packed {
      logic                 sign;
      logic                 a_neg;
      logic                 za;
      logic                 zb;
      logic signed [DW-1:0] diff;
   } s2_pay_t;

   // Zero-extend a log value into the signed difference width
   function automatic logic signed [DW-1:0] log_to_diff(input log_val_t v);
      return $signed({2'b00, v});
   endfunction

endpackage

// File: rtl/lod_log.sv
// Leading-one detect plus normalisation: unsigned value -> {k, frac} Mitchell log.
// Latency: combinational.
// Backpressure: none (pure function of its input).
module lod_log
   import approx_arith_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] val,
   output log_val_t     lv
);

   logic [KW-1:0] k_lz;
   logic [KW-1:0] sh;
   logic [W-1:0]  norm;
   logic [F-1:0]  frac;

   // Find the MSB index, shift it to the top and keep the bits below it as the fraction
   always_comb begin
      k_lz = '0;
      for (int i = 0; i < W; i++) begin
         if (val[i]) k_lz = KW'(i);
      end
      sh   = KW'(W - 1) - k_lz;
      norm = val << sh;
      frac = '0;
      frac[F-1 -: W-1] = norm[W-2:0];
      lv.k    = k_lz;
      lv.frac = frac;
   end

endmodule

// File: rtl/log_divider.sv
// Mitchell-approximation signed divider: log subtraction then antilog, with special cases.
// Latency: 3 cycles input transfer to out_valid, throughput 1 per cycle.
// Backpressure: full valid/ready; a stalled output freezes full stages, in_ready drops when S1 cannot move.
module log_divider
   import approx_arith_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic                  div_by_zero,
   output logic                  sat
);

   logic     ready_en;
   logic     s1_valid, s2_valid;
   s1_pay_t  s1_d, s1_q;
   s2_pay_t  s2_d, s2_q;
   log_val_t la, lb;
   logic     s3_en, s2_adv, s2_load, s1_adv;

   // Stage n moves when stage n+1 is empty or moving; chain is combinational from out_ready
   assign s3_en    = !out_valid | out_ready;
   assign s2_adv   = s2_valid & s3_en;
   assign s2_load  = !s2_valid | s2_adv;
   assign s1_adv   = s1_valid & s2_load;
   assign in_ready = ready_en & (!s1_valid | s1_adv);

   // Hold in_ready low until the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // S1 next state: result sign, zero flags and magnitudes (|-32768| fits as unsigned)
   always_comb begin
      s1_d.sign  = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
      s1_d.a_neg = dividend[DIVIDEND_W-1];
      s1_d.za    = (dividend == '0);
      s1_d.zb    = (divisor == '0);
      s1_d.a     = dividend[DIVIDEND_W-1] ? (-dividend) : dividend;
      s1_d.b     = divisor[DIVISOR_W-1] ? (-divisor) : divisor;
   end

   // S1 register: load on input transfer, drain when S2 takes the entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) s1_q <= s1_d;
      end
   end

   lod_log #(.W(DIVIDEND_W)) u_lod_a (.val(s1_q.a), .lv(la));
   lod_log #(.W(DIVISOR_W))  u_lod_b (.val(s1_q.b), .lv(lb));

   // S2 next state: log-domain subtraction, flags carried along
   always_comb begin
      s2_d.sign  = s1_q.sign;
      s2_d.a_neg = s1_q.a_neg;
      s2_d.za    = s1_q.za;
      s2_d.zb    = s1_q.zb;
      s2_d.diff  = log_to_diff(la) - log_to_diff(lb);
   end

   // S2 register: holds while the output stage is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_q     <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) s2_q <= s2_d;
      end
   end

   logic                  kneg, khi;
   logic [KW-1:0]         k3, sh3;
   logic [F-1:0]          f3;
   logic [DIVIDEND_W-1:0] mag;
   logic [DIVIDEND_W-1:0] q_d;
   logic                  dbz_d, sat_d;

   // S3: antilog of the difference, then sign, saturation and divide-by-zero handling
   always_comb begin
      kneg  = s2_q.diff[DW-1];
      khi   = s2_q.diff[DW-2];
      k3    = s2_q.diff[F +: KW];
      f3    = s2_q.diff[F-1:0];
      sh3   = KW'(F) - k3;
      q_d   = '0;
      dbz_d = 1'b0;
      sat_d = 1'b0;
      if (kneg)     mag = '0;                    // quotient magnitude below one
      else if (khi) mag = '1;                    // shift beyond range: force the clip path
      else          mag = {1'b1, f3} >> sh3;
      if (s2_q.zb) begin
         dbz_d = 1'b1;
         q_d   = s2_q.a_neg ? {1'b1, {F{1'b0}}} : {1'b0, {F{1'b1}}};
      end else if (s2_q.za) begin
         q_d = '0;
      end else if (!s2_q.sign) begin
         if (mag[DIVIDEND_W-1]) begin
            q_d   = {1'b0, {F{1'b1}}};
            sat_d = 1'b1;
         end else begin
            q_d = mag;
         end
      end else begin
         q_d = -mag;                             // -2^F is representable, no clip needed
      end
   end

   // Output register: update only when empty or being consumed, so results hold under stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         quotient    <= '0;
         div_by_zero <= 1'b0;
         sat         <= 1'b0;
      end else if (s3_en) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            quotient    <= q_d;
            div_by_zero <= dbz_d;
            sat         <= sat_d;
         end
      end
   end

endmodule

// File: tb/tb_log_divider.sv
// Scoreboard bench for log_divider: expected results queued at input transfer, checked by a monitor.
// Reference is a plain-arithmetic Mitchell model (log2 x ~ k + (x-2^k)/2^k in Q15).
// Covers reset, directed corner cases, latency, backpressure, random traffic and mid-flight reset.
module tb_log_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid, out_ready;
   logic [15:0] quotient;
   logic        div_by_zero, sat;

   always #5 clk = ~clk;

   log_divider dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .div_by_zero(div_by_zero), .sat(sat)
   );

   typedef struct {
      logic [15:0] q;
      logic        dbz;
      logic        sat;
   } exp_t;

   exp_t sb[$];
   int checks = 0, errors = 0;
   int pushes = 0, pops = 0, flushed = 0;
   bit held = 0;
   logic [15:0] held_q;
   logic held_dbz, held_sat;
   bit watch_ready = 0, saw_in_ready_low = 0, rand_done = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int msb_idx(input int x);
      int r = 0;
      for (int i = 0; i < 31; i++) if (x >= (1 << i)) r = i;
      return r;
   endfunction

   // Mitchell reference: approximate logs, subtract, antilog, then apply sign and special cases
   function automatic exp_t model(input int a_s, input int b_s);
      exp_t   e;
      int     a, b, ka, kb;
      longint la, lb, d, k, f, mag;
      bit     neg;
      e.dbz = 0; e.sat = 0; e.q = '0;
      if (b_s == 0) begin
         e.dbz = 1;
         e.q   = (a_s >= 0) ? 16'h7fff : 16'h8000;
         return e;
      end
      if (a_s == 0) return e;
      neg = (a_s < 0) != (b_s < 0);
      a   = (a_s < 0) ? -a_s : a_s;
      b   = (b_s < 0) ? -b_s : b_s;
      ka  = msb_idx(a);
      kb  = msb_idx(b);
      la  = longint'(ka) * 32768 + (longint'(a - (1 << ka)) << (15 - ka));
      lb  = longint'(kb) * 32768 + (longint'(b - (1 << kb)) << (15 - kb));
      d   = la - lb;
      if (d >= 0) k = d / 32768;
      else        k = -((-d + 32767) / 32768);
      f   = d - k * 32768;
      if (k < 0) mag = 0;
      else       mag = ((32768 + f) << k) >> 15;
      if (!neg) begin
         if (mag > 32767) begin e.q = 16'h7fff; e.sat = 1; end
         else e.q = 16'(mag);
      end else begin
         e.q = 16'(-mag);
      end
      return e;
   endfunction

   // Drive one input and hold it until the DUT accepts; queue the expected result on acceptance
   task automatic send(input logic [15:0] a, input logic [7:0] b, input exp_t e);
      @(negedge clk);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      for (int n = 0; ; n++) begin
         #2;
         if (in_ready) begin
            sb.push_back(e);
            pushes++;
            break;
         end
         if (n >= 300) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic sendm(input int a, input int b);
      send(16'(a), 8'(b), model(a, b));
   endtask

   task automatic sendx(input int a, input int b, input int q, input bit d, input bit s);
      exp_t e;
      e.q = 16'(q); e.dbz = d; e.sat = s;
      send(16'(a), 8'(b), e);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // Count cycles from an accept to out_valid; in_valid drops right after the accepting edge
   task automatic latency_check(input string name);
      int n;
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      #2;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk(name, n, 3);
   endtask

   // Monitor: pop and compare on every output transfer, and check stability during stalls
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 0;
         end else begin
            if (watch_ready && !in_ready) saw_in_ready_low = 1;
            if (held) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_quotient", $signed(quotient), $signed(held_q));
               chk("hold_dbz", div_by_zero, held_dbz);
               chk("hold_sat", sat, held_sat);
            end
            held = 0;
            if (out_valid) begin
               if (out_ready) begin
                  if (sb.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_output: quotient %0d with nothing pending, expected no output",
                              $signed(quotient));
                  end else begin
                     e = sb.pop_front();
                     pops++;
                     chk("quotient", $signed(quotient), $signed(e.q));
                     chk("div_by_zero", div_by_zero, e.dbz);
                     chk("sat", sat, e.sat);
                  end
               end else begin
                  held     = 1;
                  held_q   = quotient;
                  held_dbz = div_by_zero;
                  held_sat = sat;
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int da[9] = '{-100, 7, 3, -32768, -32768, 500, -5, 0, 0};
      int db[9] = '{10, 3, 7, 1, -1, 0, 0, 0, 9};
      int dq[9] = '{-10, 2, 0, -32768, 32767, 32767, -32768, 32767, 0};
      bit dd[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
      bit ds[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      int pops_before;

      rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_sat", sat, 0);
      chk("rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      chk("in_ready_after_release", in_ready, 1);

      // First transaction: value and no-stall latency
      sendx(100, 10, 10, 0, 0);
      latency_check("latency_first");
      wait_drain();

      // Directed corner cases, back to back
      for (int i = 0; i < 9; i++) sendx(da[i], db[i], dq[i], dd[i], ds[i]);
      idle();
      wait_drain();

      // Backpressure: five-deep stream with a four-cycle output stall
      watch_ready = 1; saw_in_ready_low = 0;
      fork
         begin
            sendx(100, 10, 10, 0, 0);
            sendx(7, 3, 2, 0, 0);
            sendx(3, 7, 0, 0, 0);
            sendx(64, 8, 8, 0, 0);
            sendx(-81, 9, -9, 0, 0);
            idle();
         end
         begin
            repeat (2) @(negedge clk);
            out_ready = 1'b0;
            repeat (4) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      wait_drain();
      watch_ready = 0;
      chk("in_ready_fell_under_stall", saw_in_ready_low, 1);

      // Random traffic with random output backpressure
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic signed [15:0] a16;
               logic signed [7:0]  b8;
               int r;
               r   = $urandom_range(0, 15);
               a16 = 16'($urandom_range(0, 65535));
               b8  = 8'($urandom_range(0, 255));
               if (r == 0) b8 = '0;
               if (r == 1) a16 = '0;
               if (r == 2) a16 = 16'sh8000;
               if (r == 3) b8 = (i % 2 == 0) ? 8'sd1 : -8'sd1;
               sendm(int'(a16), int'(b8));
            end
            idle();
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset with two results in flight: everything is discarded
      out_ready = 1'b0;
      sendm(1000, 7);
      sendm(-77, 5);
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("inflight_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("reset_out_valid_now", out_valid, 0);
      chk("reset_in_ready_now", in_ready, 0);
      flushed += sb.size();
      sb.delete();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pops_before = pops;
      repeat (10) @(negedge clk);
      chk("no_output_after_reset", pops, pops_before);

      // Fresh input after reset: correct value at latency 3
      sendm(42, -6);
      latency_check("latency_after_reset");
      wait_drain();

      chk("results_in_equals_out", pops, pushes - flushed);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
